// File: rtl/updown_counter.sv
// updown_counter: saturating 0..MAX_VAL up/down event counter with synchronized, edge-detected inputs; define COUNTER_WRAP_EN for wrap-around
module updown_counter #(
  parameter int BW          = 7,
  parameter int MAX_VAL     = 99,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          up_i,
  input  logic          down_i,
  output logic [BW-1:0] counter_val_o,
  output logic          at_max_o,
  output logic          at_min_o
);
`ifdef COUNTER_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif
  localparam logic [BW-1:0] MAX = BW'(MAX_VAL);
  localparam logic [BW-1:0] ONE = BW'(1);
  logic [SYNC_STAGES-1:0] up_sync_q, dn_sync_q;
  logic                   up_hist_q, dn_hist_q;
  logic                   up_e, dn_e;
  logic [BW-1:0]          cnt_q, cnt_d;
  assign up_e = up_sync_q[SYNC_STAGES-1] & ~up_hist_q;
  assign dn_e = dn_sync_q[SYNC_STAGES-1] & ~dn_hist_q;
  // next count: opposing pulses cancel, limits saturate or wrap
  always_comb begin
    cnt_d = (up_e & ~dn_e) ? ((cnt_q == MAX) ? (WRAP ? '0 : MAX) : cnt_q + ONE) :
            (dn_e & ~up_e) ? ((cnt_q == '0) ? (WRAP ? MAX : '0) : cnt_q - ONE) :
            cnt_q;
  end
  // input synchronizers, edge history and count register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      up_sync_q <= '0;
      dn_sync_q <= '0;
      up_hist_q <= 1'b0;
      dn_hist_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      up_sync_q <= {up_sync_q[SYNC_STAGES-2:0], up_i};
      dn_sync_q <= {dn_sync_q[SYNC_STAGES-2:0], down_i};
      up_hist_q <= up_sync_q[SYNC_STAGES-1];
      dn_hist_q <= dn_sync_q[SYNC_STAGES-1];
      cnt_q     <= cnt_d;
    end
  end
  assign counter_val_o = cnt_q;
  assign at_max_o      = (cnt_q == MAX);
  assign at_min_o      = (cnt_q == '0);
endmodule

// File: tb/tb_updown_counter.sv
// tb_updown_counter: directed scoreboard bench for updown_counter
module tb_updown_counter;
`ifdef COUNTER_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif
  localparam int MAXV = 99;
  logic       clk = 1'b0;
  logic       rst_i = 1'b0;
  logic       up_i = 1'b0;
  logic       down_i = 1'b0;
  logic [6:0] counter_val_o;
  logic       at_max_o;
  logic       at_min_o;
  int checks = 0;
  int errors = 0;
  int model = 0;
  int exp_q[$];

  updown_counter dut (
    .clk_i(clk),
    .rst_i(rst_i),
    .up_i(up_i),
    .down_i(down_i),
    .counter_val_o(counter_val_o),
    .at_max_o(at_max_o),
    .at_min_o(at_min_o)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  function automatic int nxt(input int v, input bit u, input bit d);
    if (u && !d) return (v == MAXV) ? (WRAP ? 0 : MAXV) : v + 1;
    if (d && !u) return (v == 0) ? (WRAP ? MAXV : 0) : v - 1;
    return v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag, input int v);
    check({tag, "_val"}, 32'(counter_val_o), 32'(v));
    check({tag, "_max"}, 32'(at_max_o), 32'(v == MAXV));
    check({tag, "_min"}, 32'(at_min_o), 32'(v == 0));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_i = 1'b0;
    #1;
    check_state("reset", 0);
    @(negedge clk);
    rst_i = 1'b1;
    model = 0;
    exp_q.delete();
  endtask

  task automatic pulse(input bit u, input bit d, input string tag);
    int prev = model;
    @(negedge clk);
    up_i = u;
    down_i = d;
    model = nxt(model, u, d);
    exp_q.push_back(model);
    @(negedge clk);
    @(negedge clk);
    check({tag, "_early"}, 32'(counter_val_o), 32'(prev));
    @(negedge clk);
    check_state(tag, exp_q.pop_front());
    @(negedge clk);
    up_i = 1'b0;
    down_i = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    repeat (6) begin
      @(negedge clk);
      up_i = ~up_i;
      down_i = ~up_i;
      check_state("in_reset", 0);
    end
    @(negedge clk);
    up_i = 1'b0;
    down_i = 1'b0;
    @(negedge clk);
    rst_i = 1'b1;
    repeat (8) @(negedge clk);
    check_state("idle", 0);

    for (int i = 0; i < 5; i++) pulse(1'b1, 1'b0, "up5");
    check_state("up5_final", 5);

    do_reset();
    for (int i = 0; i < 110; i++) pulse(1'b1, 1'b0, "uplim");
    check_state("uplim_final", WRAP ? 10 : 99);

    do_reset();
    for (int i = 0; i < 3; i++) pulse(1'b1, 1'b0, "to3");
    for (int i = 0; i < 5; i++) pulse(1'b0, 1'b1, "down");
    check_state("down_final", WRAP ? 98 : 0);

    do_reset();
    for (int i = 0; i < 50; i++) pulse(1'b1, 1'b0, "to50");
    pulse(1'b1, 1'b1, "both");
    check_state("both_final", 50);

    @(negedge clk);
    up_i = 1'b1;
    model = nxt(model, 1'b1, 1'b0);
    exp_q.push_back(model);
    @(negedge clk);
    @(negedge clk);
    check("held_early", 32'(counter_val_o), 32'd50);
    @(negedge clk);
    check_state("held", exp_q.pop_front());
    repeat (97) @(negedge clk);
    check_state("held_long", 51);
    up_i = 1'b0;
    repeat (6) @(negedge clk);
    check_state("held_release", 51);

    for (int i = 0; i < 11; i++) pulse(1'b0, 1'b1, "to40");
    check_state("at40", 40);
    @(negedge clk);
    up_i = 1'b1;
    @(posedge clk);
    #2;
    rst_i = 1'b0;
    #1;
    check_state("async_rst", 0);
    up_i = 1'b0;
    #1;
    rst_i = 1'b1;
    model = 0;
    repeat (6) @(negedge clk);
    check_state("pending_dropped", 0);

    @(negedge clk);
    rst_i = 1'b0;
    up_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b1;
    model = nxt(model, 1'b1, 1'b0);
    exp_q.push_back(model);
    @(negedge clk);
    @(negedge clk);
    check("thru_rst_early", 32'(counter_val_o), 32'd0);
    @(negedge clk);
    check_state("thru_rst", exp_q.pop_front());
    repeat (20) @(negedge clk);
    up_i = 1'b0;
    repeat (6) @(negedge clk);
    check_state("thru_rst_once", 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
